// File: rtl/deser_pkg.sv
// Shared types and defaults for the deserializer-sharing controller.
// The state enum is the controller's sequence; the constants are the default parameters.
package deser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    DELIVER
  } deser_state_t;

  localparam int DESER_N_BITS  = 8;
  localparam int DESER_CAP_DLY = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational pick, registered last-served pointer.
// On a tie the requester that was not served last wins; the pointer starts at 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt_next
);

  logic last;  // index of the requester granted most recently

  always_comb begin
    // NOTE: every path assigns gnt_next (default arm included), so no latch is inferred.
    case (req)
      2'b01:   gnt_next = 2'b01;
      2'b10:   gnt_next = 2'b10;
      2'b11:   gnt_next = last ? 2'b01 : 2'b10;
      default: gnt_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= gnt_next[1];
    end
  end

endmodule

// File: rtl/deser_arbiter.sv
// Shares one serial-to-parallel FSM between two requesters: arbitrate, start the FSM,
// stream the winner's bits, capture the parallel result and hand it back with valid/ack.
module deser_arbiter
  import deser_pkg::*;
#(
  parameter int N_BITS  = DESER_N_BITS,
  parameter int CAP_DLY = DESER_CAP_DLY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        ser_in,
  output logic [1:0]        gnt,
  output logic [1:0]        shift_en,
  output logic              fsm_start,
  output logic              fsm_in,
  input  logic [N_BITS-1:0] fsm_out,
  output logic [N_BITS-1:0] rdata,
  output logic [1:0]        rvalid,
  input  logic [1:0]        rack
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int DW = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;

  deser_state_t    state, state_nx;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dcnt;
  logic [1:0]      gnt_next;
  logic            arb_update;
  logic            capture;
  logic            last_bit;
  logic            last_wait;
  logic            ack;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .update   (arb_update),
    .gnt_next (gnt_next)
  );

  assign last_bit  = (cnt == CW'(N_BITS - 1));
  assign last_wait = (dcnt == DW'(CAP_DLY - 1));
  // gnt is one-hot during a transfer, so this is rack of the owner only
  assign ack       = |(rack & gnt);

  always_comb begin
    state_nx   = state;
    arb_update = 1'b0;
    capture    = 1'b0;
    fsm_start  = 1'b0;
    fsm_in     = 1'b0;
    shift_en   = 2'b00;
    rvalid     = 2'b00;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx   = START;
          arb_update = 1'b1;
        end
      end
      START: begin
        fsm_start = 1'b1;
        state_nx  = SHIFT;
      end
      SHIFT: begin
        shift_en = gnt;
        fsm_in   = ser_in[gnt[1]];
        if (last_bit) begin
          if (CAP_DLY == 0) begin
            state_nx = DELIVER;
            capture  = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (last_wait) begin
          state_nx = DELIVER;
          capture  = 1'b1;
        end
      end
      DELIVER: begin
        rvalid = gnt;
        if (ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 2'b00;
      cnt   <= '0;
      dcnt  <= '0;
      // NOTE: rdata is a visible output that must read 0 after reset, so it is reset like control state.
      rdata <= '0;
    end else begin
      state <= state_nx;
      if (arb_update) begin
        gnt <= gnt_next;
      end else if (state == DELIVER && ack) begin
        gnt <= 2'b00;
      end
      if (state == START) begin
        cnt <= '0;
      end else if (state == SHIFT) begin
        cnt <= cnt + CW'(1);
      end
      if (state == WAIT) begin
        dcnt <= dcnt + DW'(1);
      end else begin
        dcnt <= '0;
      end
      if (capture) rdata <= fsm_out;
    end
  end

endmodule
